// File: rtl/syn_pkg.sv
// syn_pkg: shared FSM state type and saturating weight arithmetic for the synapse bank.
package syn_pkg;
   typedef enum logic [1:0] {IDLE, FIRE, DONE} syn_state_t;

   function automatic int wmax_of(input int w);
      return (1 << w) - 1;
   endfunction

   // Evaluated in full int width, so neither direction can wrap before clamping.
   function automatic int sat_update(input int w, input logic inc, input logic dec, input int step, input int wmax);
      return (inc && !dec) ? ((w + step > wmax) ? wmax : w + step) :
             (dec && !inc) ? ((w < step) ? 0 : w - step) : w;
   endfunction
endpackage

// File: rtl/synapse_cell.sv
// synapse_cell: one synapse - spike edge detector, pulse FSM/counter and saturating weight register.
// Optional preload port under SYN_WEIGHT_LOAD_EN.
module synapse_cell
   import syn_pkg::*;
#(
   parameter int WEIGHT_W    = 3,
   parameter int INIT_WEIGHT = 0,
   parameter int STEP        = 1
) (
   input  logic                aclk,
   input  logic                rst,
   input  logic                gclk,
   input  logic                input_spike,
   input  logic                inc,
   input  logic                dec,
`ifdef SYN_WEIGHT_LOAD_EN
   input  logic                wt_load,
   input  logic [WEIGHT_W-1:0] wt_load_data,
`endif
   output logic                out,
   output logic [WEIGHT_W-1:0] weight
);
   localparam int WMAX = wmax_of(WEIGHT_W);

   syn_state_t          r_state, w_state_n;
   logic [WEIGHT_W-1:0] r_cnt, w_cnt_n, r_weight, w_weight_n;
   logic                r_spike_q, r_out, w_out_n, w_edge;

   assign w_edge = input_spike & ~r_spike_q;
   assign out    = r_out;
   assign weight = r_weight;

   // A weight-0 spike is still consumed: straight to DONE without a pulse.
   always_comb begin
      w_state_n = r_state;
      w_cnt_n   = r_cnt;
      w_out_n   = r_out;
      if (gclk) begin
         w_state_n = IDLE;
         w_out_n   = 1'b0;
      end else begin
         case (r_state)
            IDLE: if (w_edge) begin
               w_state_n = (r_weight == '0) ? DONE : FIRE;
               w_out_n   = (r_weight != '0);
               w_cnt_n   = r_weight - WEIGHT_W'(1);
            end
            FIRE: if (r_cnt == '0) begin
               w_state_n = DONE;
               w_out_n   = 1'b0;
            end else begin
               w_cnt_n = r_cnt - WEIGHT_W'(1);
            end
            default: w_out_n = 1'b0;
         endcase
      end
   end

   always_comb begin
      w_weight_n = gclk ? WEIGHT_W'(sat_update(int'(r_weight), inc, dec, STEP, WMAX)) : r_weight;
`ifdef SYN_WEIGHT_LOAD_EN
      if (wt_load) w_weight_n = wt_load_data;
`endif
   end

   always_ff @(posedge aclk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_out     <= 1'b0;
         r_spike_q <= 1'b0;
         r_weight  <= WEIGHT_W'(INIT_WEIGHT);
      end else begin
         r_state   <= w_state_n;
         r_cnt     <= w_cnt_n;
         r_out     <= w_out_n;
         r_spike_q <= input_spike;
         r_weight  <= w_weight_n;
      end
   end
endmodule

// File: rtl/synapse_bank.sv
// synapse_bank: N_SYN independent synapse_cell channels with packed weight output.
// Define SYN_WEIGHT_LOAD_EN to add the wt_load/wt_load_data preload ports.
module synapse_bank
   import syn_pkg::*;
#(
   parameter int N_SYN       = 8,
   parameter int WEIGHT_W    = 3,
   parameter int INIT_WEIGHT = 0,
   parameter int STEP        = 1
) (
   input  logic                      aclk,
   input  logic                      rst,
   input  logic                      gclk,
   input  logic [N_SYN-1:0]          input_spike,
   input  logic [N_SYN-1:0]          inc,
   input  logic [N_SYN-1:0]          dec,
`ifdef SYN_WEIGHT_LOAD_EN
   input  logic                      wt_load,
   input  logic [N_SYN*WEIGHT_W-1:0] wt_load_data,
`endif
   output logic [N_SYN-1:0]          out,
   output logic [N_SYN*WEIGHT_W-1:0] weight
);
   for (genvar i = 0; i < N_SYN; i++) begin : g_syn
      synapse_cell #(
         .WEIGHT_W(WEIGHT_W), .INIT_WEIGHT(INIT_WEIGHT), .STEP(STEP)
      ) u_cell (
         .aclk        (aclk),
         .rst         (rst),
         .gclk        (gclk),
         .input_spike (input_spike[i]),
         .inc         (inc[i]),
         .dec         (dec[i]),
`ifdef SYN_WEIGHT_LOAD_EN
         .wt_load     (wt_load),
         .wt_load_data(wt_load_data[i*WEIGHT_W +: WEIGHT_W]),
`endif
         .out         (out[i]),
         .weight      (weight[i*WEIGHT_W +: WEIGHT_W])
      );
   end
endmodule

// File: tb/tb_synapse_bank.sv
// tb_synapse_bank: two banks (4x3-bit init 3 step 1; 2x5-bit init 31 step 4) checked every cycle
// against a timeline model of accepted spikes, plus literal expectations.
module tb_synapse_bank;
   logic        aclk = 1'b0, rst = 1'b1, gclk = 1'b0, wt_load = 1'b0;
   logic [5:0]  sp = '0, inc_v = '0, dec_v = '0;
   logic [3:0]  out0;
   logic [1:0]  out1;
   logic [11:0] w0, exp_w0, ld0 = '0;
   logic [9:0]  w1, exp_w1, ld1 = '0;
   logic [5:0]  o_all, exp_out;
   int tests = 0, fails = 0, n = 0;
   bit valid = 0;
   int mw[6], prev[6], cons[6], live[6], st[6], pw[6], hi[6];
   int wmax_c[6] = '{7, 7, 7, 7, 31, 31};
   int init_c[6] = '{3, 3, 3, 3, 31, 31};
   int step_c[6] = '{1, 1, 1, 1, 4, 4};
   int inc_tab[9] = '{4, 5, 6, 7, 7, 7, 7, 7, 7};
   int dec_tab[9] = '{6, 5, 4, 3, 2, 1, 0, 0, 0};
   int b1_tab[9]  = '{27, 23, 19, 15, 11, 7, 3, 0, 0};
`ifdef SYN_WEIGHT_LOAD_EN
   localparam bit LOAD_EN = 1'b1;
`else
   localparam bit LOAD_EN = 1'b0;
`endif

   always #5 aclk = ~aclk;
   assign o_all = {out1, out0};

   synapse_bank #(.N_SYN(4), .WEIGHT_W(3), .INIT_WEIGHT(3), .STEP(1)) dut0 (
      .aclk(aclk), .rst(rst), .gclk(gclk), .input_spike(sp[3:0]), .inc(inc_v[3:0]), .dec(dec_v[3:0]),
`ifdef SYN_WEIGHT_LOAD_EN
      .wt_load(wt_load), .wt_load_data(ld0),
`endif
      .out(out0), .weight(w0));

   synapse_bank #(.N_SYN(2), .WEIGHT_W(5), .INIT_WEIGHT(31), .STEP(4)) dut1 (
      .aclk(aclk), .rst(rst), .gclk(gclk), .input_spike(sp[5:4]), .inc(inc_v[5:4]), .dec(dec_v[5:4]),
`ifdef SYN_WEIGHT_LOAD_EN
      .wt_load(wt_load), .wt_load_data(ld1),
`endif
      .out(out1), .weight(w1));

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Model: a pulse is the window [start, start+w) in edge counts, cut off by gclk.
   always @(posedge aclk) begin
      for (int c = 0; c < 6; c++) begin
         if (rst) begin
            mw[c] = init_c[c]; prev[c] = 0; cons[c] = 0; live[c] = 0;
         end else begin
            if (gclk) begin
               live[c] = 0; cons[c] = 0;
               if (inc_v[c] && !dec_v[c]) mw[c] = (mw[c] + step_c[c] > wmax_c[c]) ? wmax_c[c] : mw[c] + step_c[c];
               else if (dec_v[c] && !inc_v[c]) mw[c] = (mw[c] < step_c[c]) ? 0 : mw[c] - step_c[c];
            end else if (sp[c] && prev[c] == 0 && cons[c] == 0) begin
               cons[c] = 1;
               if (mw[c] > 0) begin live[c] = 1; st[c] = n; pw[c] = mw[c]; end
            end
            if (LOAD_EN && wt_load) mw[c] = (c < 4) ? int'(ld0[c*3 +: 3]) : int'(ld1[(c-4)*5 +: 5]);
            prev[c] = int'(sp[c]);
         end
         exp_out[c] = (live[c] != 0) && (n - st[c] < pw[c]);
         if (c < 4) exp_w0[c*3 +: 3] = 3'(mw[c]);
         else exp_w1[(c-4)*5 +: 5] = 5'(mw[c]);
      end
      n++;
      valid = 1;
   end

   always @(negedge aclk) begin
      if (valid) begin
         chk("out_bank0", int'(out0), int'(exp_out[3:0]));
         chk("out_bank1", int'(out1), int'(exp_out[5:4]));
         chk("weight_bank0", int'(w0), int'(exp_w0));
         chk("weight_bank1", int'(w1), int'(exp_w1));
      end
      for (int c = 0; c < 6; c++) if (o_all[c]) hi[c]++;
   end

   task automatic tick();
      @(negedge aclk);
      #1;
   endtask

   task automatic run_gamma(input int len, input logic [5:0] m, input int a1, input int a2,
                            input logic [5:0] iv, input logic [5:0] dv);
      for (int c = 0; c < 6; c++) hi[c] = 0;
      for (int c = 0; c < len; c++) begin
         gclk  = (c == 0);
         inc_v = iv;
         dec_v = dv;
         sp    = ((c >= a1 && c < a1 + 8) || (c >= a2 && c < a2 + 8)) ? m : '0;
         tick();
      end
      gclk = 0; inc_v = '0; dec_v = '0; sp = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      tick(); tick();
      chk("reset_weight0", int'(w0), 12'h6DB);
      chk("reset_weight1", int'(w1), 10'h3FF);
      chk("reset_out", int'(o_all), 0);
      rst = 0;
      run_gamma(24, 6'b000001, 1, -100, '0, '0);
      chk("pulse_width_w3", hi[0], 3);
      run_gamma(24, 6'b000001, 1, 12, '0, '0);
      chk("second_spike_ignored", hi[0], 3);
      for (int k = 0; k < 9; k++) begin
         run_gamma(10, '0, -100, -100, 6'b010010, 6'b100000);
         chk("sat_inc_ch1", int'(w0[5:3]), inc_tab[k]);
         chk("sat_dec_step4_ch5", int'(w1[9:5]), b1_tab[k]);
      end
      chk("sat_inc_w31_ch4", int'(w1[4:0]), 31);
      for (int k = 0; k < 9; k++) begin
         run_gamma(10, '0, -100, -100, '0, 6'b000010);
         chk("sat_dec_ch1", int'(w0[5:3]), dec_tab[k]);
      end
      run_gamma(10, 6'b000010, 2, -100, '0, '0);
      chk("weight0_no_pulse", hi[1], 0);
      run_gamma(12, 6'b000100, 0, -100, 6'b000100, 6'b000100);
      chk("inc_dec_both_hold", int'(w0[8:6]), 3);
      chk("spike_in_gclk_ignored", hi[2], 0);
      run_gamma(24, 6'b010000, 20, -100, '0, '0);
      chk("truncated_pulse_len", hi[4], 4);
      gclk = 1; tick(); gclk = 0;
      chk("truncated_at_gclk", int'(o_all[4]), 0);
      gclk = 1; tick(); gclk = 0;
      sp = 6'b000001; tick(); tick();
      chk("pulse_before_rst", int'(out0[0]), 1);
      rst = 1; tick();
      chk("rst_mid_pulse_out", int'(out0[0]), 0);
      chk("rst_mid_pulse_weight", int'(w0), 12'h6DB);
      rst = 0; sp = '0; tick();
`ifdef SYN_WEIGHT_LOAD_EN
      ld0 = {3'd2, 3'd7, 3'd0, 3'd5};
      ld1 = {5'd30, 5'd9};
      wt_load = 1; gclk = 1; inc_v = 6'b111111; tick();
      wt_load = 0; gclk = 0; inc_v = '0;
      chk("load_over_inc_bank0", int'(w0), 12'h5C5);
      chk("load_over_inc_bank1", int'(w1), 10'h3C9);
      run_gamma(24, 6'b000001, 2, -100, '0, '0);
      chk("pulse_after_load_w5", hi[0], 5);
`endif
      tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
